jtdsp16_do_seq: RTL and testbench

//  Parametrised do/redo loop sequencer for the JTDSP16 core. Sits beside the instruction

---
 rtl/jtdsp16_do_seq_pkg.sv | 6 +
 rtl/jtdsp16_cache_ram.sv | 18 +
 rtl/jtdsp16_do_seq.sv | 115 +++++++++++
 tb/tb_jtdsp16_do_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_do_seq_pkg.sv
// jtdsp16_do_seq_pkg: sequencer states and do_data field positions
package jtdsp16_do_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, REPLAY = 2'd2} state_t;
  localparam int NI_MSB = 10;
  localparam int NI_LSB = 7;
endpackage

// File: rtl/jtdsp16_cache_ram.sv
// jtdsp16_cache_ram: DEPTH x 16 loop cache, cen-gated sync write, async read
module jtdsp16_cache_ram #(
  parameter int DEPTH = 15,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   din,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   dout
);
  logic [15:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (cen && we) mem_q[waddr] <= din;
  assign dout = mem_q[raddr];
endmodule

// File: rtl/jtdsp16_do_seq.sv
// jtdsp16_do_seq: do/redo loop sequencer; define JTDSP16_REDO_EN to enable redo replay
module jtdsp16_do_seq
  import jtdsp16_do_seq_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int AW    = 4,
  parameter int CNTW  = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            do_start,
  input  logic [10:0]     do_data,
  input  logic            fetch,
  input  logic [15:0]     rom_dout,
  output logic [15:0]     cache_dout,
  output logic            cache_en,
  output logic            pc_hold,
  output logic            busy,
  output logic            no_int,
  output logic            err,
  output logic [CNTW-1:0] k_left
);
  state_t          st_q, st_d;
  logic [3:0]      ni_q, ni_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0] k_q, k_d;
  logic            err_q, err_d, valid_q, valid_d;
  logic [3:0]      ni;
  logic [CNTW-1:0] k_in;
  logic            last_w, last_r, we;
  logic [15:0]     rd;
  assign ni     = do_data[NI_MSB:NI_LSB];
  assign k_in   = do_data[CNTW-1:0];
  assign last_w = wptr_q == AW'(ni_q - 4'd1);
  assign last_r = rptr_q == AW'(ni_q - 4'd1);
  // a reset cycle must not land a stray write from an aborted fill
  assign we     = fetch && st_q == FILL && !rst;
  always_comb begin
    st_d    = st_q;
    ni_d    = ni_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    k_d     = k_q;
    valid_d = valid_q;
    err_d   = cen ? 1'b0 : err_q;
    if (cen && do_start) begin
      if (st_q != IDLE) err_d = 1'b1;
      else if (ni == 4'd0) begin
`ifdef JTDSP16_REDO_EN
        if (valid_q && k_in != '0) begin
          st_d   = REPLAY;
          k_d    = k_in - CNTW'(1);
          rptr_d = '0;
        end else err_d = 1'b1;
`else
        err_d = 1'b1;
`endif
      end else if (int'(ni) > DEPTH || k_in == '0) err_d = 1'b1;
      else begin
        st_d    = FILL;
        ni_d    = ni;
        k_d     = k_in - CNTW'(1);
        wptr_d  = '0;
        valid_d = 1'b0;
      end
    end
    if (cen && fetch && st_q == FILL) begin
      wptr_d = last_w ? '0 : wptr_q + AW'(1);
      if (last_w) begin
        valid_d = 1'b1;
        rptr_d  = '0;
        st_d    = k_q != '0 ? REPLAY : IDLE;
        k_d     = k_q != '0 ? k_q - CNTW'(1) : k_q;
      end
    end
    // k_left counts passes still to run after the one being replayed
    if (cen && fetch && st_q == REPLAY) begin
      rptr_d = last_r ? '0 : rptr_q + AW'(1);
      if (last_r) begin
        st_d = k_q != '0 ? REPLAY : IDLE;
        k_d  = k_q != '0 ? k_q - CNTW'(1) : k_q;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      st_q    <= IDLE;
      ni_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      ni_q    <= ni_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      k_q     <= k_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  jtdsp16_cache_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .cen(cen), .we(we), .waddr(wptr_q), .din(rom_dout),
    .raddr(rptr_q), .dout(rd)
  );
  assign busy       = st_q != IDLE;
  assign no_int     = busy;
  assign cache_en   = st_q == REPLAY;
  assign pc_hold    = cache_en;
  assign cache_dout = cache_en ? rd : '0;
  assign err        = err_q;
  assign k_left     = k_q;
endmodule

// File: tb/tb_jtdsp16_do_seq.sv
// tb_jtdsp16_do_seq: randomized loop scenarios checked against expected word/pass sequences
module tb_jtdsp16_do_seq;
  logic        clk = 0, rst = 1, cen = 0, do_start = 0, fetch = 0;
  logic [10:0] do_data = '0;
  logic [15:0] rom_dout = '0;
  logic [15:0] cache_dout;
  logic        cache_en, pc_hold, busy, no_int, err;
  logic [6:0]  k_left;
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] cur_w[$];

  jtdsp16_do_seq dut (
    .clk(clk), .rst(rst), .cen(cen), .do_start(do_start), .do_data(do_data),
    .fetch(fetch), .rom_dout(rom_dout), .cache_dout(cache_dout), .cache_en(cache_en),
    .pc_hold(pc_hold), .busy(busy), .no_int(no_int), .err(err), .k_left(k_left)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_do(input logic [3:0] ni, input int k);
    cen = 1; fetch = 0; do_start = 1; do_data = {ni, 7'(k)};
    tick;
    do_start = 0;
  endtask

  // optional idle gap, optional cen-stalled fetch carrying a wrong word, then the real fetch
  task automatic fetch_one(input logic [15:0] w);
    if ($urandom_range(0, 3) == 0) begin cen = 1; fetch = 0; tick; end
    if ($urandom_range(0, 3) == 0) begin cen = 0; fetch = 1; rom_dout = ~w; tick; end
    cen = 1; fetch = 1; rom_dout = w;
    tick;
    fetch = 0; rom_dout = $urandom;
  endtask

  // passes of cur_w from the cache; nest fires a do_start at the start of the first pass
  task automatic replay(input int passes, input bit nest);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < cur_w.size(); i++) begin
        n_cmp++;
        if ({busy, no_int, cache_en, pc_hold, err} !== 5'b11110) begin
          n_bad++;
          $display("FAIL replay_flags p=%0d i=%0d got %b want 11110", p, i, {busy, no_int, cache_en, pc_hold, err});
        end
        n_cmp++;
        if (cache_dout !== cur_w[i]) begin
          n_bad++;
          $display("FAIL replay_word p=%0d i=%0d got %h want %h", p, i, cache_dout, cur_w[i]);
        end
        n_cmp++;
        if (k_left !== 7'(passes - 1 - p)) begin
          n_bad++;
          $display("FAIL replay_k_left p=%0d got %0d want %0d", p, k_left, passes - 1 - p);
        end
        if (nest && p == 0 && i == 0) begin
          start_do(4'd2, 5);
          n_cmp++;
          if ({busy, cache_en, err, k_left} !== {3'b111, 7'(passes - 1)}) begin
            n_bad++;
            $display("FAIL nested_do got busy/en/err=%b k=%0d want 111 k=%0d", {busy, cache_en, err}, k_left, passes - 1);
          end
        end
        fetch_one(cur_w[i]);
      end
    n_cmp++;
    if ({busy, no_int, cache_en, pc_hold, err, k_left, cache_dout} !== '0) begin
      n_bad++;
      $display("FAIL loop_end got flags=%b k=%0d dout=%h want all 0", {busy, no_int, cache_en, pc_hold, err}, k_left, cache_dout);
    end
  endtask

  task automatic run_loop(input int ni, input int k, input bit nest);
    cur_w.delete();
    for (int i = 0; i < ni; i++) cur_w.push_back(16'($urandom));
    start_do(4'(ni), k);
    n_cmp++;
    if ({busy, no_int, cache_en, pc_hold, err, k_left} !== {5'b11000, 7'(k - 1)}) begin
      n_bad++;
      $display("FAIL do_accept ni=%0d k=%0d got %b k=%0d want 11000 k=%0d", ni, k, {busy, no_int, cache_en, pc_hold, err}, k_left, k - 1);
    end
    for (int i = 0; i < ni; i++) begin
      n_cmp++;
      if ({busy, cache_en, pc_hold} !== 3'b100) begin
        n_bad++;
        $display("FAIL fill_flags i=%0d got %b want 100", i, {busy, cache_en, pc_hold});
      end
      fetch_one(cur_w[i]);
    end
    replay(k - 1, nest);
  endtask

  task automatic test_reset;
    rst = 1; cen = 0; do_start = 0; fetch = 0;
    tick; tick;
    n_cmp++;
    if ({busy, no_int, cache_en, pc_hold, err, k_left, cache_dout} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got flags=%b k=%0d dout=%h want all 0", {busy, no_int, cache_en, pc_hold, err}, k_left, cache_dout);
    end
    rst = 0;
  endtask

  task automatic test_do_basic;
    run_loop(3, 4, 0);
    for (int t = 0; t < 6; t++) run_loop($urandom_range(1, 15), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    run_loop(1, 3, 0);
  endtask

  task automatic test_fill_only;
    run_loop(2, 1, 0);
  endtask

  task automatic test_reject;
    start_do(4'd2, 0);
    n_cmp++;
    if ({busy, no_int, cache_en, pc_hold, err} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reject_k0 got %b want 00001", {busy, no_int, cache_en, pc_hold, err});
    end
    start_do(4'd15, 0);
    n_cmp++;
    if ({busy, err} !== 2'b01) begin
      n_bad++;
      $display("FAIL reject_ni15_k0 got %b want 01", {busy, err});
    end
    tick;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse_clear got %b want 0", err);
    end
    cen = 0; do_start = 1; do_data = {4'd3, 7'd4};
    tick; tick;
    do_start = 0; cen = 1;
    n_cmp++;
    if ({busy, err} !== 2'b00) begin
      n_bad++;
      $display("FAIL do_with_cen0 got %b want 00", {busy, err});
    end
  endtask

  task automatic test_nested;
    run_loop(3, 3, 1);
  endtask

  task automatic test_reset_mid;
    run_loop(3, 1, 0);
    start_do(4'd3, 3);
    for (int i = 0; i < 5; i++) begin cen = 1; fetch = 1; rom_dout = $urandom; tick; end
    fetch = 0; rst = 1;
    tick;
    n_cmp++;
    if ({busy, no_int, cache_en, pc_hold, err, k_left, cache_dout} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid got flags=%b k=%0d dout=%h want all 0", {busy, no_int, cache_en, pc_hold, err}, k_left, cache_dout);
    end
    rst = 0;
    start_do(4'd0, 2);
    n_cmp++;
    if ({busy, err} !== 2'b01) begin
      n_bad++;
      $display("FAIL redo_after_reset got %b want 01", {busy, err});
    end
  endtask

  task automatic test_redo;
    run_loop(3, 4, 0);
    start_do(4'd0, 2);
`ifdef JTDSP16_REDO_EN
    replay(2, 0);
    start_do(4'd0, 0);
    n_cmp++;
    if ({busy, err} !== 2'b01) begin
      n_bad++;
      $display("FAIL redo_k0 got %b want 01", {busy, err});
    end
`else
    n_cmp++;
    if ({busy, no_int, cache_en, pc_hold, err} !== 5'b00001) begin
      n_bad++;
      $display("FAIL redo_disabled got %b want 00001", {busy, no_int, cache_en, pc_hold, err});
    end
`endif
    tick;
  endtask

  task automatic test_back_to_back;
    run_loop(4, 2, 0);
    run_loop(2, 3, 0);
  endtask

  initial begin
    test_reset;
    test_do_basic;
    test_fill_only;
    test_reject;
    test_nested;
    test_redo;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
